// File: rtl/bicubic_pkg.sv
// bicubic_pkg: constants and helpers shared by the horizontal and vertical
// bicubic accumulators.
//   PIX_W   - pixel / product magnitude width
//   TAPS    - taps per bicubic window
//   TC_W    - two's complement width of one tap (sign + magnitude)
//   SUM_W   - width of the four-tap sum (range -1020..+1020)
//   PIX_MAX - largest representable output pixel
//   sm_to_tc(sign, mag) - sign-magnitude to TC_W-bit two's complement
package bicubic_pkg;

    localparam int PIX_W   = 8;
    localparam int TAPS    = 4;
    localparam int TC_W    = 9;
    localparam int SUM_W   = 11;
    localparam int PIX_MAX = 255;

    // A negative zero negates to zero, so no special case is needed.
    function automatic logic signed [TC_W-1:0] sm_to_tc(input logic sign,
                                                        input logic [PIX_W-1:0] mag);
        logic signed [TC_W-1:0] ext;
        ext = $signed({1'b0, mag});
        return sign ? -ext : ext;
    endfunction

endpackage

// File: rtl/bicubic_sm2tc.sv
// bicubic_sm2tc: combinational sign-magnitude to two's complement converter
// for one tap product.
//   sign - 1 = negative
//   mag  - PIX_W-bit magnitude
//   tc   - TC_W-bit signed result
module bicubic_sm2tc
    import bicubic_pkg::*;
(
    input  logic                   sign,
    input  logic [PIX_W-1:0]       mag,
    output logic signed [TC_W-1:0] tc
);

    assign tc = sm_to_tc(sign, mag);

endmodule

// File: rtl/bicubic_tap_accum.sv
// bicubic_tap_accum: sums the four signed tap products of one bicubic window
// into one pixel through a two-stage elastic pipeline.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake, beat taken on in_valid & in_ready
//   in_prod             - tap k magnitude at [8k+7:8k]
//   in_sign             - tap k sign at bit k (1 = negative)
//   in_tag              - sideband carried alongside the beat
//   out_valid/out_ready - output handshake, result taken on out_valid & out_ready
//   out_pix, out_sign   - result magnitude and sign (sign forced 0 when CLAMP=1)
//   out_tag             - in_tag of the same beat
// CLAMP=1 clamps the sum to 0..255; CLAMP=0 saturates |sum| to 255 and keeps
// the sign.
module bicubic_tap_accum
    import bicubic_pkg::*;
#(
    parameter int CLAMP = 1,
    parameter int TAG_W = 2
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W*TAPS-1:0]    in_prod,
    input  logic [TAPS-1:0]          in_sign,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_pix,
    output logic                     out_sign,
    output logic [TAG_W-1:0]         out_tag
);

    logic                    s1_valid;
    logic                    s1_en;
    logic                    s2_en;
    logic signed [TC_W-1:0]  tap_tc [TAPS];
    logic signed [TC_W:0]    p01;
    logic signed [TC_W:0]    p23;
    logic [TAG_W-1:0]        s1_tag;
    logic signed [SUM_W-1:0] sum;
    logic [SUM_W-1:0]        sum_abs;
    logic [PIX_W-1:0]        pix_next;
    logic                    sign_next;

    genvar k;
    generate
        for (k = 0; k < TAPS; k++) begin : g_tap
            bicubic_sm2tc u_sm2tc (
                .sign (in_sign[k]),
                .mag  (in_prod[PIX_W*k +: PIX_W]),
                .tc   (tap_tc[k])
            );
        end
    endgenerate

    // Handshake: a stage advances when it is empty or the stage after it
    // advances. Stage 2 advances when out_valid is low or out_ready is high;
    // stage 1 when it is empty or stage 2 advances. in_ready depends only on
    // registered valids and out_ready, never on in_valid, so the pipeline
    // holds two beats and accept and emit can happen in the same cycle.
    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;

    // Stage-2 result from the registered pair sums.
    always_comb begin
        sum       = {p01[TC_W], p01} + {p23[TC_W], p23};
        sum_abs   = sum[SUM_W-1] ? SUM_W'(-sum) : SUM_W'(sum);
        pix_next  = '0;
        sign_next = 1'b0;
        if ((CLAMP != 0) && sum[SUM_W-1]) begin
            pix_next = '0;
        end else if (sum_abs > SUM_W'(PIX_MAX)) begin
            pix_next = PIX_W'(PIX_MAX);
        end else begin
            pix_next = sum_abs[PIX_W-1:0];
        end
        // A zero sum has sum[MSB]=0, so the sign is never set on zero.
        sign_next = (CLAMP == 0) && sum[SUM_W-1];
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sign  <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                // Outputs only change when a real beat moves in.
                if (s1_valid) begin
                    out_pix  <= pix_next;
                    out_sign <= sign_next;
                    out_tag  <= s1_tag;
                end
            end
        end
    end

    // Stage-1 data registers carry no reset; s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            p01    <= {tap_tc[0][TC_W-1], tap_tc[0]} + {tap_tc[1][TC_W-1], tap_tc[1]};
            p23    <= {tap_tc[2][TC_W-1], tap_tc[2]} + {tap_tc[3][TC_W-1], tap_tc[3]};
            s1_tag <= in_tag;
        end
    end

endmodule

// File: tb/tb_bicubic_tap_accum.sv
module tb_bicubic_tap_accum;

    localparam int TAG_W = 3;
    localparam int EXP_W = TAG_W + 18;  // {tag, clamp pix, clamp sign, signed pix, signed sign}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid;
    logic [31:0]      in_prod;
    logic [3:0]       in_sign;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             a_in_ready, a_out_valid, a_out_sign;
    logic [7:0]       a_out_pix;
    logic [TAG_W-1:0] a_out_tag;
    logic             b_in_ready, b_out_valid, b_out_sign;
    logic [7:0]       b_out_pix;
    logic [TAG_W-1:0] b_out_tag;

    bicubic_tap_accum #(.CLAMP(1), .TAG_W(TAG_W)) u_clamp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_prod(in_prod), .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pix(a_out_pix),
        .out_sign(a_out_sign), .out_tag(a_out_tag)
    );

    bicubic_tap_accum #(.CLAMP(0), .TAG_W(TAG_W)) u_signed (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pix(b_out_pix),
        .out_sign(b_out_sign), .out_tag(b_out_tag)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int pops  = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic [TAG_W-1:0] t, input int pc,
                                              input int sc, input int ps, input int ss);
        return {t, 8'(pc), 1'(sc), 8'(ps), 1'(ss)};
    endfunction

    // Arithmetic reference for the random stream.
    function automatic logic [EXP_W-1:0] model(input logic [31:0] p, input logic [3:0] sg,
                                               input logic [TAG_W-1:0] t);
        int s, c, m;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            m = int'(p[8*k +: 8]);
            s = sg[k] ? s - m : s + m;
        end
        c = (s < 0) ? 0 : (s > 255) ? 255 : s;
        m = (s < 0) ? -s : s;
        if (m > 255) m = 255;
        return pack(t, c, 0, m, (s < 0) ? 1 : 0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] p, input logic [3:0] s, input logic [TAG_W-1:0] t,
                        input logic [EXP_W-1:0] e, output int waits);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        waits = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_sign  = s;
        in_tag   = t;
        while (!done && n < 200) begin
            @(negedge clk);
            if (a_in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", int'(done), 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    logic             stalled = 1'b0;
    logic [EXP_W-1:0] held;
    logic [EXP_W-1:0] cur;
    logic [EXP_W-1:0] e;

    always @(negedge clk) begin
        cur = {a_out_tag, a_out_pix, a_out_sign, b_out_pix, b_out_sign};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", int'(a_out_valid), 1);
                check("stall_data_held", int'(cur), int'(held));
            end
            stalled = a_out_valid && !out_ready;
            held = cur;
            if (a_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_q_size", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    check("tag", int'(a_out_tag), int'(e[EXP_W-1 -: TAG_W]));
                    check("clamp_pix", int'(a_out_pix), int'(e[17:10]));
                    check("clamp_sign", int'(a_out_sign), int'(e[9]));
                    check("signed_valid", int'(b_out_valid), 1);
                    check("signed_tag", int'(b_out_tag), int'(e[EXP_W-1 -: TAG_W]));
                    check("signed_pix", int'(b_out_pix), int'(e[8:1]));
                    check("signed_sign", int'(b_out_sign), int'(e[0]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int p0;
        logic [31:0] rp;
        logic [3:0]  rs;

        rst = 1'b1;
        in_valid = 1'b0;
        in_prod = '0;
        in_sign = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(a_out_valid), 0);
        check("reset_out_pix", int'(a_out_pix), 0);
        check("reset_out_sign", int'(a_out_sign), 0);
        check("reset_out_tag", int'(a_out_tag), 0);
        check("reset_in_ready", int'(a_in_ready), 1);
        check("reset_signed_valid", int'(b_out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sum: -2 + 22 + 86 - 7 = 99, with latency check.
        send({8'd7, 8'd86, 8'd22, 8'd2}, 4'b1001, 3'd1, pack(3'd1, 99, 0, 99, 0), w);
        in_valid = 1'b0;
        check("latency_cycle1_valid", int'(a_out_valid), 0);
        @(posedge clk);
        #1;
        check("latency_cycle2_valid", int'(a_out_valid), 1);
        drain("drain_basic");

        // Boundary vectors, back-to-back.
        send({8'd0, 8'd255, 8'd255, 8'd255}, 4'b0000, 3'd2, pack(3'd2, 255, 0, 255, 0), w);
        send({8'd50, 8'd0, 8'd100, 8'd200}, 4'b0011, 3'd3, pack(3'd3, 0, 0, 250, 1), w);
        send(32'd0, 4'b1111, 3'd4, pack(3'd4, 0, 0, 0, 0), w);
        send({8'd0, 8'd255, 8'd255, 8'd255}, 4'b1111, 3'd5, pack(3'd5, 0, 0, 255, 1), w);
        send({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0000, 3'd6, pack(3'd6, 255, 0, 255, 0), w);
        send({8'd0, 8'd0, 8'd1, 8'd255}, 4'b0000, 3'd7, pack(3'd7, 255, 0, 255, 0), w);
        send({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0001, 3'd0, pack(3'd0, 0, 0, 255, 1), w);
        send({8'd10, 8'd0, 8'd0, 8'd0}, 4'b1000, 3'd1, pack(3'd1, 0, 0, 10, 1), w);
        in_valid = 1'b0;
        drain("drain_boundary");

        // Backpressure: out_ready low for cycles 3..7 while 6 beats stream.
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send({16'd0, 8'd5, 8'(20 * k + 30)}, 4'b0010, 3'(k),
                         pack(3'(k), 20 * k + 25, 0, 20 * k + 25, 0), w);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c >= 3 && c <= 7) check("bp_in_ready_low", int'(a_in_ready), 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Full throughput: 64 random beats, one per clock.
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 64; i++) begin
            rp = $urandom;
            rs = 4'($urandom_range(0, 15));
            send(rp, rs, 3'(i), model(rp, rs, 3'(i)), w);
            check("tp_in_ready_no_wait", w, 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("tp_result_count", pops - p0, 64);
        drain("drain_throughput");

        // Reset with two beats in flight.
        send({8'd0, 8'd0, 8'd0, 8'd77}, 4'b0000, 3'd2, pack(3'd2, 77, 0, 77, 0), w);
        send({8'd0, 8'd0, 8'd0, 8'd88}, 4'b0000, 3'd3, pack(3'd3, 88, 0, 88, 0), w);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", int'(a_out_valid), 0);
        check("midreset_signed_valid", int'(b_out_valid), 0);
        check("midreset_out_pix", int'(a_out_pix), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle_valid", int'(a_out_valid), 0);
        send({8'd0, 8'd0, 8'd0, 8'd42}, 4'b0000, 3'd6, pack(3'd6, 42, 0, 42, 0), w);
        in_valid = 1'b0;
        check("post_reset_latency1", int'(a_out_valid), 0);
        @(posedge clk);
        #1;
        check("post_reset_latency2", int'(a_out_valid), 1);
        drain("drain_reset");
        repeat (4) @(posedge clk);
        #1;
        check("final_idle_valid", int'(a_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
